// File: rtl/bcd_countdown_timer_if.sv
// Keypad/display bundle for the BCD countdown timer: load/count controls in,
// BCD digits plus zero/done status out.
interface bcd_countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 1
);
  logic [3:0]              data;
  logic                    loadn;
  logic                    en;
  logic                    add30;
  logic [3:0]              sec_ones;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    zero;
  logic                    done;

  modport master (
    output data, loadn, en, add30,
    input  sec_ones, sec_tens, mins, zero, done
  );

  modport slave (
    input  data, loadn, en, add30,
    output sec_ones, sec_tens, mins, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown with serial digit load, pause, saturating
// +30 s quick-add and a one-cycle expiry pulse.
module bcd_countdown_timer #(
  parameter int unsigned MIN_DIGITS    = 1,
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input logic                  clock,
  input logic                  clearn,
  bcd_countdown_timer_if.slave bus
);
  localparam int unsigned MW = 4 * MIN_DIGITS;
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [MW-1:0] mins_q, mins_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic          zero_c;
  logic          tick_c;
  logic          carry;
  logic          borrow;
  logic [3:0]    digit;

  assign zero_c = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == '0);
  assign tick_c = bus.loadn && bus.en && !zero_c && (presc_q == PRESC_MAX);

  // Next-state: load shift, or add30 followed by tick decrement, then saturate.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    mins_d     = mins_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    carry      = 1'b0;
    borrow     = 1'b0;
    digit      = 4'd0;

    if (!bus.loadn) begin
      mins_d     = MW'({mins_q, sec_tens_q});
      sec_tens_d = (sec_ones_q > 4'd5) ? 4'd5 : sec_ones_q;
      sec_ones_d = (bus.data > 4'd9) ? 4'd9 : bus.data;
      presc_d    = '0;
    end else begin
      if (bus.add30) begin
        if (sec_tens_q > 4'd2) begin
          sec_tens_d = sec_tens_q - 4'd3;
          carry      = 1'b1;
        end else begin
          sec_tens_d = sec_tens_q + 4'd3;
        end
        for (int k = 0; k < int'(MIN_DIGITS); k++) begin
          digit = mins_d[4*k +: 4];
          if (carry) begin
            if (digit == 4'd9) begin
              mins_d[4*k +: 4] = 4'd0;
            end else begin
              mins_d[4*k +: 4] = digit + 4'd1;
              carry            = 1'b0;
            end
          end
        end
      end

      if (tick_c) begin
        if (sec_ones_d != 4'd0) begin
          sec_ones_d = sec_ones_d - 4'd1;
        end else begin
          sec_ones_d = 4'd9;
          if (sec_tens_d != 4'd0) begin
            sec_tens_d = sec_tens_d - 4'd1;
          end else begin
            sec_tens_d = 4'd5;
            borrow     = 1'b1;
          end
          for (int k = 0; k < int'(MIN_DIGITS); k++) begin
            digit = mins_d[4*k +: 4];
            if (borrow) begin
              if (digit == 4'd0) begin
                mins_d[4*k +: 4] = 4'd9;
              end else begin
                mins_d[4*k +: 4] = digit - 4'd1;
                borrow           = 1'b0;
              end
            end
          end
        end
      end

      // A carry out of the top minute digit means the sum passed the maximum.
      if (carry) begin
        sec_ones_d = 4'd9;
        sec_tens_d = 4'd5;
        mins_d     = {MIN_DIGITS{4'd9}};
      end

      done_d = tick_c && (sec_ones_d == 4'd0) && (sec_tens_d == 4'd0) && (mins_d == '0);

      if (zero_c) begin
        presc_d = '0;
      end else if (bus.en) begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      mins_q     <= '0;
      presc_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      mins_q     <= mins_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
    end
  end

  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.mins     = mins_q;
  assign bus.zero     = zero_c;
  assign bus.done     = done_q;
endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised BCD minutes:seconds countdown timer, the next-generation timing core for the microwave controller. It accepts digits serially from the keypad path and counts down one second per programmable number of clock ticks. It supports pause and resume, a saturating "+30 s" quick-add, and a one-cycle `done` pulse when a running countdown expires. Display and beeper logic sit downstream and consume `sec_ones`, `sec_tens`, `mins`, `zero` and `done`.

## Interface
- `MIN_DIGITS`, default 1: number of BCD minute digits (1..4).
- `TICKS_PER_SEC`, default 1: enabled clock cycles per one-second decrement (>=1). The prescaler width is clog2(TICKS_PER_SEC), minimum 1 bit.

- `clock` in 1: single clock; all state changes on its rising edge.
- `clearn` in 1: reset; asynchronous, active-low.
- `data` in 4: BCD digit to shift in during load.
- `loadn` in 1: active-low load; each edge with `loadn`=0 shifts one digit in.
- `en` in 1: count enable; 0 pauses the timer.
- `add30` in 1: single-cycle request to add 30 s.
- `sec_ones` out 4: seconds units digit, 0..9.
- `sec_tens` out 4: seconds tens digit, 0..5.
- `mins` out 4*MIN_DIGITS: minute digits, least significant digit in bits [3:0].
- `zero` out 1: high when all digits are 0. Combinational from the digit registers.
- `done` out 1: registered one-cycle expiry pulse.

## Operation
- **Reset** (`clearn`=0, asynchronous): all digits 0, prescaler 0, `done`=0. As a result, `zero`=1.
- **Priority** per edge: reset > load > count/add30.
- **Load** (`loadn`=0): shift left one digit per edge.
  - Each minute digit k takes the value of digit k-1.
  - `mins[3:0]` takes `sec_tens`.
  - `sec_tens` takes `sec_ones`, clamped to 5 if greater than 5.
  - `sec_ones` takes `data`, clamped to 9 if greater than 9.
  - Prescaler is cleared; `add30` and `en` are ignored; `done` is 0.
- **Count** (`loadn`=1, `en`=1, `zero`=0):
  - The prescaler increments each cycle.
  - At TICKS_PER_SEC-1 it wraps to 0 and the time decrements by 1 s.
  - Decrement borrows: `sec_ones` 0->9 borrows from `sec_tens`; `sec_tens` 0->5 borrows from `mins`; minute digits borrow BCD 0->9 upward.
- **Pause** (`en`=0): digits and prescaler hold. The partial second is preserved.
- **At zero**: no decrement occurs and the prescaler is held at 0, regardless of `en`.
- **add30** (`loadn`=1, independent of `en`): time += 30 s in BCD.
  - `sec_tens`+3 with carry into `mins` when the result exceeds 5.
  - The result saturates at the maximum value: all minute digits 9, `sec_tens`=5, `sec_ones`=9.
  - The prescaler is unaffected.
- **add30 coincident with a decrement tick**: net change is +29 s, computed as add-then-subtract, with saturation applied after.
- **add30 while at zero**: yields 0:30. No decrement applies that cycle because the timer was zero at the edge.
- **done**: set for exactly one cycle when a decrement takes the time from 0:01 to 0:00.
  - It is never set by reset or by loading zeros.
  - It is never set by remaining at zero.

## Timing
- Load latency: a digit appears on `sec_ones` 1 edge after being sampled. Three edges load M:ST.
- First decrement occurs on the TICKS_PER_SEC-th enabled edge after a load or reset, since the prescaler starts at 0.
- `done` and `zero` rise together on the edge that produces 0:00. `done` falls on the next edge.
- Reset mid-count: outputs go to zero immediately, with no clock required; `done`=0.
- Deasserting `loadn` with `en`=1 starts the prescaler on that same edge.

## Test plan
- **Reset**: assert `clearn`=0 -> all digits 0, `zero`=1, `done`=0.
- **Load and count** (MIN_DIGITS=1, TICKS_PER_SEC=1):
  - Load 8, 5, 7 -> 8:57.
  - Set `en`=1 -> 8:56 after 1 edge; 8:00 after 57 edges; 7:59 on the next edge.
  - Loading 9, 7 -> `sec_tens` clamps to 5.
- **Expiry** (TICKS_PER_SEC=4): load 0:02, `en`=1 -> 0:01 at edge 4, 0:00 at edge 8, `done` high for exactly edge 8-9, then the display stays 0:00 with `done`=0.
- **Pause** (TICKS_PER_SEC=4):
  - Deassert `en` after 2 prescaler counts for 10 cycles -> no change.
  - Re-enable -> the decrement occurs after 2 more enabled edges.
- **add30**:
  - At 0:45 -> 1:15.
  - Coincident with a tick at 0:45 -> 1:14.
  - MIN_DIGITS=2 at 99:50 -> 99:59 (saturated).
  - At 0:00 -> 0:30, with no `done`.
- **Asynchronous reset mid-count**: pulse `clearn` low between edges at 3:21 -> immediate 0:00 with `done`=0; no counting until a reload.
